// File: rtl/dot_product_lanes.sv
// dot_product_lanes
//   Fixed-point dot-product engine: F = sum_k H[k] * x[k], with H signed
//   (HW bits) and x unsigned (XW bits), evaluated LANES elements per beat.
//   A vector takes B = ceil(J/LANES) beats plus a two-cycle multiply/add
//   pipeline, so a vector accepted at cycle T produces f_valid at T+B+2.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high. x_valid may not depend on x_ready. f_valid stays
//   high and f_data stays stable until f_ready is seen.
//   h_valid has no ready; it always loads h_data into the shadow register.
//
//   Configuration macro: DOTP_SATURATE_EN. When OW < AW, f_data saturates
//   if the macro is defined and wraps if it is not. It has no effect when
//   OW >= AW.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     h_data       J*HW coefficients, element k at [k*HW +: HW]
//     h_valid      load h_data into the shadow coefficient register
//     x_data       J*XW symbols, element k at [k*XW +: XW]
//     x_valid      symbol vector valid
//     x_ready      engine can accept a vector
//     f_data       OW-bit signed result
//     f_valid      result valid
//     f_ready      downstream accepts result
//     busy         engine is not idle
module dot_product_lanes #(
    parameter int J     = 14,
    parameter int LANES = 2,
    parameter int HW    = 32,
    parameter int XW    = 2,
    parameter int OW    = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [J*HW-1:0]   h_data,
    input  logic              h_valid,
    input  logic [J*XW-1:0]   x_data,
    input  logic              x_valid,
    output logic              x_ready,
    output logic [OW-1:0]     f_data,
    output logic              f_valid,
    input  logic              f_ready,
    output logic              busy
);

    localparam int B  = (J + LANES - 1) / LANES;
    localparam int PW = HW + XW + 1;
    localparam int AW = HW + XW + 1 + $clog2(J);
    localparam int CW = $clog2(B + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                 accept;
    logic                 last_beat;
    logic [CW-1:0]        cnt;
    logic [J*HW-1:0]      h_shadow;
    logic [J*HW-1:0]      h_act;
    logic [J*XW-1:0]      x_reg;
    logic signed [PW-1:0] prod [LANES];
    logic                 prod_vld;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] lane_sum;
    logic signed [AW-1:0] acc_sum;
    logic [OW-1:0]        f_reg;
    logic [OW-1:0]        f_conv;

    // Per-lane operand tables indexed by beat. Slots past element J-1 are
    // tied to zero so they contribute nothing. The extra entry at index B
    // covers the flush cycle and keeps the table index exactly CW bits wide.
    logic signed [HW-1:0] h_tab  [LANES][B+1];
    logic [XW-1:0]        x_tab  [LANES][B+1];
    logic signed [HW-1:0] h_lane [LANES];
    logic signed [XW:0]   x_lane [LANES];

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        for (genvar gb = 0; gb <= B; gb++) begin : g_beat
            if ((gb * LANES + gl) < J) begin : g_live
                assign h_tab[gl][gb] = h_act[(gb*LANES+gl)*HW +: HW];
                assign x_tab[gl][gb] = x_reg[(gb*LANES+gl)*XW +: XW];
            end else begin : g_mask
                assign h_tab[gl][gb] = '0;
                assign x_tab[gl][gb] = '0;
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            h_lane[l] = h_tab[l][cnt];
            x_lane[l] = {1'b0, x_tab[l][cnt]};
        end
    end

    assign accept    = x_valid & x_ready;
    assign last_beat = (state == S_RUN) && (cnt == CW'(B));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN:  if (last_beat) state_nxt = S_OUT;
            S_OUT: begin
                if (f_ready) begin
                    state_nxt = x_valid ? S_RUN : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        x_ready = 1'b0;
        f_valid = 1'b0;
        busy    = 1'b1;
        case (state)
            S_IDLE: begin
                x_ready = 1'b1;
                busy    = 1'b0;
            end
            S_OUT: begin
                x_ready = f_ready;
                f_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Shadow coefficients follow h_valid in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_shadow <= '0;
        end else if (h_valid) begin
            h_shadow <= h_data;
        end
    end

    // Operands are frozen at accept; a coincident h_valid bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_act <= '0;
            x_reg <= '0;
        end else if (accept) begin
            h_act <= h_valid ? h_data : h_shadow;
            x_reg <= x_data;
        end
    end

    // Stage 1: beat counter and registered lane products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prod_vld <= 1'b0;
            for (int l = 0; l < LANES; l++) prod[l] <= '0;
        end else if (accept) begin
            cnt      <= '0;
            prod_vld <= 1'b0;
        end else if (state == S_RUN) begin
            if (cnt < CW'(B)) begin
                cnt      <= cnt + 1'b1;
                prod_vld <= 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    prod[l] <= PW'(h_lane[l]) * PW'(x_lane[l]);
                end
            end else begin
                prod_vld <= 1'b0;
            end
        end
    end

    // Stage 2: lane adder tree and accumulator.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + AW'(prod[l]);
        end
    end

    assign acc_sum = acc + lane_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (state == S_RUN && prod_vld) begin
            acc <= acc_sum;
        end
    end

    // Output conversion of the final sum (acc_sum on the last RUN cycle).
    if (OW >= AW) begin : g_extend
        assign f_conv = OW'(acc_sum);
    end else begin : g_narrow
`ifdef DOTP_SATURATE_EN
        localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
        localparam logic [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};
        localparam logic signed [AW-1:0] SAT_MAX = AW'(OUT_MAX);
        localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
        assign f_conv = (acc_sum > SAT_MAX) ? OUT_MAX :
                        (acc_sum < SAT_MIN) ? OUT_MIN : OW'(acc_sum);
`else
        assign f_conv = OW'(acc_sum);
`endif
    end

    // f_data is only updated on entry to OUT, so it stays put through
    // back-pressure and through the next vector's RUN phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_reg <= '0;
        end else if (last_beat) begin
            f_reg <= f_conv;
        end
    end

    assign f_data = f_reg;

endmodule

// File: doc/dot_product_lanes.md
# dot_product_lanes

Parametrised fixed-point dot-product engine. It computes F = sum over k of H[k]·x[k] for a J-element coefficient vector H and a J-element unsigned symbol vector x, using LANES parallel multipliers. It adds ready/valid back-pressure on both sides and shadow-buffered coefficient loading. It sits between the symbol source and the metric/decision stage, and throughput scales with LANES.

## Interface
Parameters:
- J, 14, vector length (≥1)
- LANES, 2, parallel multipliers (1..J)
- HW, 32, coefficient width, signed two's complement
- XW, 2, symbol width, unsigned
- OW, 48, output width, signed

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- h_data  in  J*HW  coefficients; element k at [k*HW +: HW]
- h_valid  in  1  load h_data into shadow register
- x_data  in  J*XW  symbols; element k at [k*XW +: XW]
- x_valid  in  1  symbol vector valid
- x_ready  out  1  engine can accept a vector
- f_data  out  OW  result
- f_valid  out  1  result valid
- f_ready  in  1  downstream accepts result
- busy  out  1  state ≠ IDLE

## Operation
- B = ceil(J/LANES) beats per vector. Lane slots with index ≥ J contribute 0.
- Shadow H register: captured on any cycle with h_valid, in every state.
- Active H register: loaded from the shadow on x accept (x_valid & x_ready). If h_valid coincides with the accept, h_data bypasses the shadow and the new values are used.
- h_valid during RUN changes only the shadow. It never affects the vector in flight.
- FSM:
  - IDLE → RUN on accept: capture x, clear accumulator, beat index = 0.
  - RUN: each beat multiplies LANES elements into registered products (stage 1). The lane products are summed and added to the accumulator (stage 2). After beat B−1 plus 2 flush cycles → OUT.
  - OUT: f_valid = 1 and f_data is held stable.
    - f_ready & x_valid → RUN (back-to-back vector accepted).
    - f_ready & !x_valid → IDLE.
- x_ready = (state == IDLE) | (state == OUT & f_ready).
- Arithmetic:
  - x is zero-extended to XW+1 bits.
  - Each product is exactly HW+XW+1 bits.
  - Accumulator width AW = HW+XW+1+clog2(J). It is exact and never overflows.
- Output conversion: if OW ≥ AW, f_data is the sign-extended accumulator. If OW < AW, see Configuration.
- Reset, including mid-operation:
  - State → IDLE.
  - All registers cleared to 0.
  - The in-flight vector is discarded and no f_valid is produced.

## Timing
- Reset values: x_ready = 1, f_valid = 0, f_data = 0, busy = 0.
- For an accept at cycle T, f_valid rises at T+B+2. Default parameters give T+9.
- Sustained throughput: one vector per B+2 cycles, with the accept overlapping the f handshake.
- f_data changes only on entry to OUT and is stable while f_valid & !f_ready.
- x_data is sampled only at accept. It need not be held afterwards.

## Configuration
- DOTP_SATURATE_EN
  - Defined: when OW < AW, f_data saturates to [−2^(OW−1), 2^(OW−1)−1].
  - Undefined: f_data = accumulator[OW−1:0], i.e. wrap-around.
  - No effect when OW ≥ AW.

## Test plan
Parameters are the defaults unless stated; T is the accept cycle.
- **Basic:** H all 1, x all 3, accept at T → f_data = 42, f_valid first high at T+9. busy high from T+1 until f handshake.
- **Signed mix:** H[k] = −1000·k, x[k] = k mod 4 → f_data = −127000.
- **Back-pressure:** hold f_ready = 0 for 5 cycles in OUT → f_data stable, x_ready = 0.
  - Raise f_ready with x_valid = 1 → new vector accepted in the same cycle, next f_valid 9 cycles later.
- **Coefficient timing:**
  - h_valid (H = all 2) in the accept cycle, x all 1 → 28.
  - h_valid (H = all 5) at T+3 → current result 28, next vector (x all 1) gives 70.
- **Width, OW=16, H all 0x7FFFFFFF, x all 3:**
  - With DOTP_SATURATE_EN → 32767.
  - Without it → 0xFFD6.
- **Lanes and reset:**
  - LANES=4 (B=4, 2 masked slots), H = 1, x = 1 → 14 at T+6.
  - Assert rst_n low at T+3 → no f_valid, x_ready = 1, and the next vector gives a correct result.
